// File: rtl/dt_arbiter.sv
// Round-robin arbiter sharing one Domain_Transfer unit between two requesters, with
// operand latching, launch pulse, done rising-edge detect, watchdog and per-port response.
module dt_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    input  logic             req0_tomont,
    input  logic [WIDTH-1:0] req0_px,
    input  logic [WIDTH-1:0] req0_py,
    input  logic [WIDTH-1:0] req0_prime,
    output logic             req0_ready,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_px,
    output logic [WIDTH-1:0] rsp0_py,
    output logic             rsp0_err,

    input  logic             req1_valid,
    input  logic             req1_tomont,
    input  logic [WIDTH-1:0] req1_px,
    input  logic [WIDTH-1:0] req1_py,
    input  logic [WIDTH-1:0] req1_prime,
    output logic             req1_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_px,
    output logic [WIDTH-1:0] rsp1_py,
    output logic             rsp1_err,

    output logic             dt_in_sig,
    output logic             dt_tomont,
    output logic [WIDTH-1:0] dt_px,
    output logic [WIDTH-1:0] dt_py,
    output logic [WIDTH-1:0] dt_prime,
    input  logic [WIDTH-1:0] dt_px_out,
    input  logic [WIDTH-1:0] dt_py_out,
    input  logic             dt_done
);

    localparam int unsigned   WdW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             gnt_q, gnt_d;
    logic             tomont_q, tomont_d;
    logic [WIDTH-1:0] px_q, px_d, py_q, py_d, prime_q, prime_d;
    logic [WIDTH-1:0] rsp_px_q, rsp_px_d, rsp_py_q, rsp_py_d;
    logic             err_q, err_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic             done_q;

    logic grant;
    logic accept;
    logic rsp_hs;
    logic done_rise;
    logic wd_expired;

    // Both valid: alternate away from whoever was served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept     = (state_q == StIdle) && (grant ? req1_valid : req0_valid);
    assign rsp_hs     = (state_q == StResp) && (gnt_q ? rsp1_ready : rsp0_ready);
    // Edge detect keeps a done level left high by a previous op from completing this one.
    assign done_rise  = dt_done && !done_q;
    assign wd_expired = (wd_q == WdMax);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StLaunch;
            StLaunch: state_d = StWait;
            StWait:   if (done_rise || wd_expired) state_d = StResp;
            StResp:   if (rsp_hs) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        tomont_d     = tomont_q;
        px_d         = px_q;
        py_d         = py_q;
        prime_d      = prime_q;
        rsp_px_d     = rsp_px_q;
        rsp_py_d     = rsp_py_q;
        err_d        = err_q;
        wd_d         = wd_q;
        if (accept) begin
            gnt_d    = grant;
            tomont_d = grant ? req1_tomont : req0_tomont;
            px_d     = grant ? req1_px     : req0_px;
            py_d     = grant ? req1_py     : req0_py;
            prime_d  = grant ? req1_prime  : req0_prime;
        end
        if (state_q == StLaunch) begin
            wd_d = '0;
        end
        if (state_q == StWait) begin
            if (done_rise) begin
                rsp_px_d = dt_px_out;
                rsp_py_d = dt_py_out;
                err_d    = 1'b0;
            end else if (wd_expired) begin
                rsp_px_d = '0;
                rsp_py_d = '0;
                err_d    = 1'b1;
            end else begin
                wd_d = wd_q + WdW'(1);
            end
        end
        if (rsp_hs) begin
            last_grant_d = gnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            tomont_q     <= 1'b0;
            px_q         <= '0;
            py_q         <= '0;
            prime_q      <= '0;
            rsp_px_q     <= '0;
            rsp_py_q     <= '0;
            err_q        <= 1'b0;
            wd_q         <= '0;
            done_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            tomont_q     <= tomont_d;
            px_q         <= px_d;
            py_q         <= py_d;
            prime_q      <= prime_d;
            rsp_px_q     <= rsp_px_d;
            rsp_py_q     <= rsp_py_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
            done_q       <= dt_done;
        end
    end

    always_comb begin
        req0_ready = accept && !grant;
        req1_ready = accept && grant;

        rsp0_valid = (state_q == StResp) && !gnt_q;
        rsp1_valid = (state_q == StResp) && gnt_q;
        rsp0_px    = rsp0_valid ? rsp_px_q : '0;
        rsp0_py    = rsp0_valid ? rsp_py_q : '0;
        rsp0_err   = rsp0_valid && err_q;
        rsp1_px    = rsp1_valid ? rsp_px_q : '0;
        rsp1_py    = rsp1_valid ? rsp_py_q : '0;
        rsp1_err   = rsp1_valid && err_q;

        dt_in_sig  = (state_q == StLaunch);
        dt_tomont  = (state_q == StLaunch) && tomont_q;
        dt_px      = (state_q != StIdle) ? px_q    : '0;
        dt_py      = (state_q != StIdle) ? py_q    : '0;
        dt_prime   = (state_q != StIdle) ? prime_q : '0;
    end

endmodule

// File: tb/tb_dt_arbiter.sv
// Directed bench for dt_arbiter: single op, contention, timeout, backpressure, stale done,
// and reset during WAIT, with the Domain_Transfer unit driven cycle-by-cycle from here.
module tb_dt_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_tomont, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic [W-1:0] req0_px, req0_py, req0_prime, rsp0_px, rsp0_py;
    logic         req1_valid, req1_tomont, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [W-1:0] req1_px, req1_py, req1_prime, rsp1_px, rsp1_py;
    logic         dt_in_sig, dt_tomont, dt_done;
    logic [W-1:0] dt_px, dt_py, dt_prime, dt_px_out, dt_py_out;

    int n_vec = 0;
    int n_err = 0;

    dt_arbiter #(.WIDTH(W), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_tomont(req0_tomont), .req0_px(req0_px),
        .req0_py(req0_py), .req0_prime(req0_prime), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_px(rsp0_px),
        .rsp0_py(rsp0_py), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_tomont(req1_tomont), .req1_px(req1_px),
        .req1_py(req1_py), .req1_prime(req1_prime), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_px(rsp1_px),
        .rsp1_py(rsp1_py), .rsp1_err(rsp1_err),
        .dt_in_sig(dt_in_sig), .dt_tomont(dt_tomont), .dt_px(dt_px), .dt_py(dt_py),
        .dt_prime(dt_prime), .dt_px_out(dt_px_out), .dt_py_out(dt_py_out), .dt_done(dt_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err,
                            rsp1_err, dt_in_sig, dt_tomont}, 64'd0);
        chk({tag, "_rsp0"}, {rsp0_px, rsp0_py}, 64'd0);
        chk({tag, "_rsp1"}, {rsp1_px, rsp1_py}, 64'd0);
        chk({tag, "_dtops"}, {dt_px, dt_py}, 64'd0);
        chk({tag, "_dtprime"}, {32'd0, dt_prime}, 64'd0);
    endtask

    // One full transaction: accept, launch, dly cycles to done (or timeout), response with
    // stall cycles of backpressure, then handshake.
    task automatic run_op(input int id, input int dly, input logic [W-1:0] rx,
                          input logic [W-1:0] ry, input int stall, input bit scramble,
                          input bit to, input bit keep_done, input int drop_at);
        logic [W-1:0] ex, ey, ep, qx, qy;
        logic         et;
        ex = (id == 1) ? req1_px : req0_px;
        ey = (id == 1) ? req1_py : req0_py;
        ep = (id == 1) ? req1_prime : req0_prime;
        et = (id == 1) ? req1_tomont : req0_tomont;
        qx = to ? '0 : rx;
        qy = to ? '0 : ry;
        #1;
        chk("ready0", {63'd0, req0_ready}, {63'd0, id == 0});
        chk("ready1", {63'd0, req1_ready}, {63'd0, id == 1});
        step();
        if (scramble) begin
            req0_valid = 1'b0; req0_px = ~req0_px; req0_py = ~req0_py;
            req0_prime = ~req0_prime; req0_tomont = ~req0_tomont;
        end
        #1;
        chk("launch_sig", {63'd0, dt_in_sig}, 64'd1);
        chk("launch_dir", {63'd0, dt_tomont}, {63'd0, et});
        chk("launch_ops", {dt_px, dt_py}, {ex, ey});
        chk("launch_prime", {32'd0, dt_prime}, {32'd0, ep});
        for (int i = 1; i <= dly; i++) begin
            step();
            if (i == drop_at) dt_done = 1'b0;
            #1;
            chk("wait_ctl", {58'd0, dt_in_sig, dt_tomont, req0_ready, req1_ready,
                             rsp0_valid, rsp1_valid}, 64'd0);
            chk("wait_ops", {dt_px, dt_py}, {ex, ey});
        end
        if (!to) begin
            dt_done = 1'b1; dt_px_out = rx; dt_py_out = ry;
        end
        step();
        if (!keep_done) dt_done = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) step();
            #1;
            chk("rsp_valid", {62'd0, rsp1_valid, rsp0_valid},
                {62'd0, id == 1, id == 0});
            chk("rsp_data", (id == 1) ? {rsp1_px, rsp1_py} : {rsp0_px, rsp0_py}, {qx, qy});
            chk("rsp_err", {63'd0, (id == 1) ? rsp1_err : rsp0_err}, {63'd0, to});
            chk("rsp_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
            chk("rsp_ops", {dt_px, dt_py}, {ex, ey});
        end
        if (id == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk("post_rsp", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        chk("post_ops", {dt_px, dt_py}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_tomont = 0; req0_px = 0; req0_py = 0; req0_prime = 0;
        req1_valid = 0; req1_tomont = 0; req1_px = 0; req1_py = 0; req1_prime = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        dt_done = 0; dt_px_out = 0; dt_py_out = 0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk_zero("reset");

        // Single request, operands scrambled after acceptance.
        req0_valid = 1; req0_tomont = 1; req0_px = 32'h1; req0_py = 32'h2;
        req0_prime = 32'hFFFF_FFFB;
        run_op(0, 34, 32'h11, 32'h22, 0, 1'b1, 1'b0, 1'b0, -1);

        // Contention from reset: 0,1,0,1.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0_valid = 1; req0_tomont = 0; req0_px = 32'hA0; req0_py = 32'hA1;
        req0_prime = 32'hFFFF_FFC5;
        req1_valid = 1; req1_tomont = 1; req1_px = 32'hB0; req1_py = 32'hB1;
        req1_prime = 32'hFFFF_FFF1;
        run_op(0, 5, 32'h100, 32'h101, 0, 1'b0, 1'b0, 1'b0, -1);
        run_op(1, 7, 32'h200, 32'h201, 0, 1'b0, 1'b0, 1'b0, -1);
        run_op(0, 3, 32'h300, 32'h301, 0, 1'b0, 1'b0, 1'b0, -1);
        run_op(1, 4, 32'h400, 32'h401, 0, 1'b0, 1'b0, 1'b0, -1);

        // Watchdog timeout on requester 1.
        req0_valid = 0;
        run_op(1, 64, 32'hAA, 32'hBB, 0, 1'b0, 1'b1, 1'b0, -1);

        // Backpressure on rsp0 with req1 pending; req1 served right after.
        req0_valid = 1;
        run_op(0, 10, 32'h33, 32'h44, 5, 1'b0, 1'b0, 1'b0, -1);
        run_op(1, 6, 32'h35, 32'h46, 0, 1'b0, 1'b0, 1'b0, -1);

        // Stale done level carried into the next op, dropped and re-raised at 34.
        req1_valid = 0;
        run_op(0, 8, 32'h77, 32'h88, 0, 1'b0, 1'b0, 1'b1, -1);
        run_op(0, 34, 32'h55, 32'h66, 0, 1'b0, 1'b0, 1'b0, 5);

        // Reset during WAIT; dropped op must never answer.
        req0_px = 32'hC0; req0_py = 32'hC1; req0_prime = 32'hC2; req0_tomont = 1;
        #1;
        step();
        req0_valid = 0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk_zero("reset_mid");
        repeat (23) step();
        dt_done = 1; dt_px_out = 32'hEE; dt_py_out = 32'hEF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dropped", {61'd0, rsp0_valid, rsp1_valid, dt_in_sig}, 64'd0);
        end
        dt_done = 0;
        step();
        req0_valid = 1; req0_px = 32'hD0; req0_py = 32'hD1;
        run_op(0, 12, 32'h99, 32'h9A, 0, 1'b0, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dt_arbiter.md
Name: dt_arbiter

Overview:
Shares a single Domain_Transfer (Montgomery to/from conversion) unit between two requesters, for example the scalar-multiply controller and the point-add unit. It arbitrates requests round-robin and latches operands. It issues the one-cycle in_sig/ToMont launch pulse and holds operands stable for the whole conversion. It waits for done with a watchdog and returns results over a valid/ready response channel to the granted requester.

Parameters:
WIDTH, 32, operand/result width (Px, Py, Prime)
TIMEOUT, 64, max cycles waited in WAIT for a done rising edge before aborting with error

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a conversion request
req0_tomont  in  1  1 = to Montgomery domain, 0 = from Montgomery domain
req0_px  in  WIDTH  input X coordinate
req0_py  in  WIDTH  input Y coordinate
req0_prime  in  WIDTH  field prime
req0_ready  out  1  request accepted this cycle when high with req0_valid
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 consumes result
rsp0_px  out  WIDTH  converted X
rsp0_py  out  WIDTH  converted Y
rsp0_err  out  1  1 = watchdog timeout, results forced to 0
req1_* / rsp1_*  same set for requester 1
dt_in_sig  out  1  launch pulse to Domain_Transfer
dt_tomont  out  1  direction, valid with dt_in_sig
dt_px, dt_py, dt_prime  out  WIDTH  latched operands to Domain_Transfer
dt_px_out, dt_py_out  in  WIDTH  Domain_Transfer results
dt_done  in  1  Domain_Transfer completion (level or pulse)

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so requester 0 wins first; watchdog counter 0; done_q 0.
- Reset mid-operation: next cycle IDLE with all outputs 0. Any in-flight request is dropped and never answered; the requester re-issues.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE, grant selection:
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - reqN_ready is combinational: (state==IDLE) && reqN_valid && grant==N. At most one ready high.
  - On valid&ready (cycle T): latch tomont, px, py, prime and grant id into registers; go to LAUNCH.
- LAUNCH (T+1):
  - dt_in_sig=1 for exactly this cycle; dt_tomont = latched direction.
  - Clear the watchdog; go to WAIT.
  - dt_tomont=0 in all other cycles.
- dt_px/dt_py/dt_prime: driven from the operand registers from T+1 until leaving RESP; 0 in IDLE.
- WAIT:
  - done_q registers dt_done every cycle. Completion = dt_done && !done_q, i.e. rising edge only, so a stale level-high done from a previous op never completes early.
  - On completion: capture dt_px_out/dt_py_out, err=0, go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 without completion: results 0, err=1, go to RESP.
  - Completion and timeout in the same cycle: completion wins (err=0).
- RESP:
  - rspN_valid=1 for the granted id only, with rspN_px/py/err held stable.
  - Stay until rspN_ready. On that cycle go to IDLE and set last_grant = granted id.
  - No new grant while in RESP.
  - rspN_valid is 0 for the non-granted requester and outside RESP.
- Latency: rsp valid asserts 1 cycle after the dt_done rising edge. Minimum accept-to-launch is 1 cycle. Back-to-back throughput is 1 op per (DT latency + 3 + response stall) cycles.
- Requests are not retracted by the arbiter. Requester operands may change after acceptance; the arbiter uses latched copies.
- Arithmetic: only the watchdog counter, width clog2(TIMEOUT), saturating at TIMEOUT-1. No data arithmetic.

Test Plan:
1. Single request: req0 tomont=1, px=0x1, py=0x2, prime=0xFFFFFFFB. DT model raises done 34 cycles after in_sig, returning 0x11/0x22. Required: one dt_in_sig pulse with dt_tomont=1, operands stable throughout; rsp0_valid 1 cycle after done with px=0x11, py=0x22, err=0.
2. Contention: req0 and req1 valid together from reset. Required: grant order 0,1,0,1 over four ops; never both ready; rsp routed only to the granted port.
3. Timeout: DT model never asserts done (TIMEOUT=64). Required: rsp1_valid with err=1, px=py=0, 64 cycles after entering WAIT.
4. Backpressure: rsp0_ready held low 5 cycles with req1 pending. Required: rsp0 data/valid stable; req1_ready stays 0 until the cycle after the rsp0 handshake.
5. Stale done: dt_done held high from the prior op into the next launch, then dropped and re-raised at cycle 34. Required: completion only on the re-raise, with correct data.
6. Reset in WAIT, cycle 10, with the DT model raising done at cycle 34. Required: all outputs 0 the next cycle; no rsp ever emitted for the dropped op; a fresh req0 is accepted normally.
